// File: rtl/rh_axi4_aw_arbiter.sv
// Round-robin arbiter sharing one AXI4 AW channel through a registered output slice.
// Define RH_AXI4_AW_ARB_QOS_EN to arbitrate by highest AWQOS (round-robin on ties).
module rh_axi4_aw_arbiter #(
  parameter int NREQ = 4,
  parameter int IW = 4,
  parameter int AW = 32,
  localparam int LW = $clog2(NREQ)
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic [NREQ-1:0]   s_awvalid,
  output logic [NREQ-1:0]   s_awready,
  input  logic [NREQ*IW-1:0] s_awid,
  input  logic [NREQ*AW-1:0] s_awaddr,
  input  logic [NREQ*8-1:0] s_awlen,
  input  logic [NREQ*3-1:0] s_awsize,
  input  logic [NREQ*2-1:0] s_awburst,
  input  logic [NREQ-1:0]   s_awlock,
  input  logic [NREQ*4-1:0] s_awcache,
  input  logic [NREQ*3-1:0] s_awprot,
  input  logic [NREQ*4-1:0] s_awqos,
  input  logic [NREQ*4-1:0] s_awregion,
  output logic              AWVALID,
  input  logic              AWREADY,
  output logic [IW+LW-1:0]  AWID,
  output logic [AW-1:0]     AWADDR,
  output logic [7:0]        AWLEN,
  output logic [2:0]        AWSIZE,
  output logic [1:0]        AWBURST,
  output logic              AWLOCK,
  output logic [3:0]        AWCACHE,
  output logic [2:0]        AWPROT,
  output logic [3:0]        AWQOS,
  output logic [3:0]        AWREGION,
  output logic [LW-1:0]     grant_idx
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t state_q, state_d;
  logic [LW-1:0] rr_ptr;
  logic [LW-1:0] win;
  logic any;
  logic can_load;
  logic load;
  int sel;
`ifdef RH_AXI4_AW_ARB_QOS_EN
  logic [3:0] best_qos;
`endif

  // Search starts at rr_ptr so the earliest hit in the loop wins ties
  always_comb begin
    win = '0;
    any = 1'b0;
    sel = 0;
`ifdef RH_AXI4_AW_ARB_QOS_EN
    best_qos = '0;
`endif
    for (int k = 0; k < NREQ; k++) begin
      sel = (int'(rr_ptr) + k) % NREQ;
`ifdef RH_AXI4_AW_ARB_QOS_EN
      if (s_awvalid[sel] &&
          (!any || s_awqos[sel*4 +: 4] > best_qos)) begin
        any = 1'b1;
        win = LW'(sel);
        best_qos = s_awqos[sel*4 +: 4];
      end
`else
      if (s_awvalid[sel] && !any) begin
        any = 1'b1;
        win = LW'(sel);
      end
`endif
    end
  end

  assign can_load = (state_q == EMPTY) | AWREADY;
  assign load = can_load & any;
  assign AWVALID = (state_q == FULL);

  always_comb begin
    s_awready = '0;
    if (load && !ARESET) s_awready[win] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: if (load) state_d = FULL;
      FULL:  if (AWREADY && !load) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q <= EMPTY;
      rr_ptr <= '0;
    end else begin
      state_q <= state_d;
      if (load)
        rr_ptr <= (win == LW'(NREQ - 1)) ? '0 : win + 1'b1;
    end
  end

  // Payload registers hold their last value once drained
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      AWID <= '0;
      AWADDR <= '0;
      AWLEN <= '0;
      AWSIZE <= '0;
      AWBURST <= '0;
      AWLOCK <= 1'b0;
      AWCACHE <= '0;
      AWPROT <= '0;
      AWQOS <= '0;
      AWREGION <= '0;
      grant_idx <= '0;
    end else if (load) begin
      AWID <= {win, s_awid[int'(win)*IW +: IW]};
      AWADDR <= s_awaddr[int'(win)*AW +: AW];
      AWLEN <= s_awlen[int'(win)*8 +: 8];
      AWSIZE <= s_awsize[int'(win)*3 +: 3];
      AWBURST <= s_awburst[int'(win)*2 +: 2];
      AWLOCK <= s_awlock[win];
      AWCACHE <= s_awcache[int'(win)*4 +: 4];
      AWPROT <= s_awprot[int'(win)*3 +: 3];
      AWQOS <= s_awqos[int'(win)*4 +: 4];
      AWREGION <= s_awregion[int'(win)*4 +: 4];
      grant_idx <= win;
    end
  end

endmodule

// File: tb/tb_rh_axi4_aw_arbiter.sv
// Randomized bench for rh_axi4_aw_arbiter against a transaction-level model.
// Model follows RH_AXI4_AW_ARB_QOS_EN the same way as the design build.
module tb_rh_axi4_aw_arbiter;
  localparam int N = 4;
  localparam int IW = 4;
  localparam int AW = 32;
  localparam int LW = 2;
  localparam int VW = 1 + N + LW + IW + LW + AW + 8 + 4 + 17;

  logic ACLK = 1'b0;
  logic ARESET;
  logic [N-1:0] s_awvalid, s_awready, s_awlock;
  logic [N*IW-1:0] s_awid;
  logic [N*AW-1:0] s_awaddr;
  logic [N*8-1:0] s_awlen;
  logic [N*3-1:0] s_awsize, s_awprot;
  logic [N*2-1:0] s_awburst;
  logic [N*4-1:0] s_awcache, s_awqos, s_awregion;
  logic AWVALID, AWREADY, AWLOCK;
  logic [IW+LW-1:0] AWID;
  logic [AW-1:0] AWADDR;
  logic [7:0] AWLEN;
  logic [2:0] AWSIZE, AWPROT;
  logic [1:0] AWBURST;
  logic [3:0] AWCACHE, AWQOS, AWREGION;
  logic [LW-1:0] grant_idx;

  int total, bad;

  // Model: one slot plus a rotating priority pointer
  bit m_full, n_full;
  logic [IW+LW-1:0] m_id, n_id;
  logic [AW-1:0] m_addr, n_addr;
  logic [7:0] m_len, n_len;
  logic [3:0] m_qos, n_qos;
  logic [16:0] m_misc, n_misc;
  logic [LW-1:0] m_grant, n_grant;
  int m_rr, n_rr;
  int exp_win;
  logic [N-1:0] exp_rdy;

  rh_axi4_aw_arbiter #(.NREQ(N), .IW(IW), .AW(AW)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen),
    .s_awsize(s_awsize), .s_awburst(s_awburst), .s_awlock(s_awlock),
    .s_awcache(s_awcache), .s_awprot(s_awprot), .s_awqos(s_awqos),
    .s_awregion(s_awregion),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWID(AWID),
    .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
    .AWBURST(AWBURST), .AWLOCK(AWLOCK), .AWCACHE(AWCACHE),
    .AWPROT(AWPROT), .AWQOS(AWQOS), .AWREGION(AWREGION),
    .grant_idx(grant_idx)
  );

  always #5 ACLK = ~ACLK;

  function automatic logic [VW-1:0] obs();
    return {AWVALID, s_awready, grant_idx, AWID, AWADDR, AWLEN,
            AWQOS, AWSIZE, AWBURST, AWLOCK, AWCACHE, AWPROT, AWREGION};
  endfunction

  function automatic logic [VW-1:0] expv();
    return {m_full, exp_rdy, m_grant, m_id, m_addr, m_len,
            m_qos, m_misc};
  endfunction

  function automatic logic [16:0] misc_of(int i);
    return {s_awsize[i*3 +: 3], s_awburst[i*2 +: 2], s_awlock[i],
            s_awcache[i*4 +: 4], s_awprot[i*3 +: 3],
            s_awregion[i*4 +: 4]};
  endfunction

  task automatic model_reset();
    m_full = 0; m_id = '0; m_addr = '0; m_len = '0;
    m_qos = '0; m_misc = '0; m_grant = '0; m_rr = 0;
  endtask

  // Winner = max of (qos, closeness to rr pointer) as a single score
  task automatic predict();
    int best, score, i;
    bit can;
    best = -1;
    exp_win = -1;
    for (int d = 0; d < N; d++) begin
      i = (m_rr + d) % N;
      if (s_awvalid[i]) begin
`ifdef RH_AXI4_AW_ARB_QOS_EN
        score = int'(s_awqos[i*4 +: 4]) * N + (N - 1 - d);
`else
        score = N - 1 - d;
`endif
        if (score > best) begin
          best = score;
          exp_win = i;
        end
      end
    end
    can = !m_full || AWREADY;
    exp_rdy = '0;
    n_full = m_full; n_id = m_id; n_addr = m_addr; n_len = m_len;
    n_qos = m_qos; n_misc = m_misc; n_grant = m_grant; n_rr = m_rr;
    if (can && exp_win >= 0) begin
      exp_rdy[exp_win] = 1'b1;
      n_full = 1;
      n_id = {LW'(exp_win), s_awid[exp_win*IW +: IW]};
      n_addr = s_awaddr[exp_win*AW +: AW];
      n_len = s_awlen[exp_win*8 +: 8];
      n_qos = s_awqos[exp_win*4 +: 4];
      n_misc = misc_of(exp_win);
      n_grant = LW'(exp_win);
      n_rr = (exp_win + 1) % N;
    end else if (m_full && AWREADY) begin
      n_full = 0;
    end
  endtask

  task automatic commit();
    @(posedge ACLK);
    m_full = n_full; m_id = n_id; m_addr = n_addr; m_len = n_len;
    m_qos = n_qos; m_misc = n_misc; m_grant = n_grant; m_rr = n_rr;
    #1;
  endtask

  task automatic rand_fields();
    s_awid = 16'($urandom);
    s_awaddr = {$urandom, $urandom, $urandom, $urandom};
    s_awlen = $urandom;
    s_awsize = 12'($urandom);
    s_awburst = 8'($urandom);
    s_awlock = 4'($urandom);
    s_awcache = 16'($urandom);
    s_awprot = 12'($urandom);
    s_awqos = 16'($urandom);
    s_awregion = 16'($urandom);
  endtask

  task automatic do_reset();
    ARESET = 1;
    s_awvalid = '0;
    @(posedge ACLK);
    #1;
    ARESET = 0;
    model_reset();
  endtask

  task automatic test_reset();
    ARESET = 1;
    s_awvalid = '0;
    AWREADY = 0;
    rand_fields();
    model_reset();
    repeat (2) @(posedge ACLK);
    @(negedge ACLK);
    total++;
    if (obs() !== '0) begin
      bad++;
      $display("FAIL reset_state got %h want 0", obs());
    end
    @(posedge ACLK);
    #1;
    ARESET = 0;
    s_awvalid = 4'b0001;
    @(negedge ACLK);
    predict();
    total++;
    if (obs() !== expv()) begin
      bad++;
      $display("FAIL reset_load got %h want %h", obs(), expv());
    end
    commit();
    #2 ARESET = 1;
    #1;
    total++;
    if ({AWVALID, s_awready, AWADDR} !== '0) begin
      bad++;
      $display("FAIL async_reset got %b/%b/%h want 0/0/0",
               AWVALID, s_awready, AWADDR);
    end
    @(posedge ACLK);
    #1;
    ARESET = 0;
    model_reset();
    s_awvalid = '1;
    @(negedge ACLK);
    predict();
    total++;
    if (s_awready !== 4'b0001) begin
      bad++;
      $display("FAIL rr_after_reset got %b want 0001", s_awready);
    end
    total++;
    if (obs() !== expv()) begin
      bad++;
      $display("FAIL rr_after_reset_all got %h want %h", obs(), expv());
    end
    commit();
  endtask

  task automatic test_single();
    do_reset();
    rand_fields();
    s_awvalid = 4'b0100;
    s_awaddr[2*AW +: AW] = 32'h1000;
    s_awid[2*IW +: IW] = 4'h5;
    AWREADY = 1;
    @(negedge ACLK);
    predict();
    total++;
    if (s_awready !== 4'b0100) begin
      bad++;
      $display("FAIL single_ready got %b want 0100", s_awready);
    end
    total++;
    if (obs() !== expv()) begin
      bad++;
      $display("FAIL single_load got %h want %h", obs(), expv());
    end
    commit();
    s_awvalid = '0;
    @(negedge ACLK);
    predict();
    total++;
    if ({AWVALID, AWADDR, AWID} !== {1'b1, 32'h1000, 2'd2, 4'h5}) begin
      bad++;
      $display("FAIL single_out got %b/%h/%h want 1/00001000/25",
               AWVALID, AWADDR, AWID);
    end
    total++;
    if (s_awready !== 4'b0000) begin
      bad++;
      $display("FAIL single_idle_ready got %b want 0000", s_awready);
    end
    commit();
    @(negedge ACLK);
    predict();
    total++;
    if (obs() !== expv() || AWVALID !== 1'b0) begin
      bad++;
      $display("FAIL single_drain got %h want %h", obs(), expv());
    end
    commit();
  endtask

  task automatic test_back_to_back();
    do_reset();
    AWREADY = 1;
    s_awvalid = '1;
    for (int c = 0; c < 12; c++) begin
      rand_fields();
      @(negedge ACLK);
      predict();
      total++;
      if (s_awready !== 4'(1 << (c % 4)) || AWVALID !== (c > 0)) begin
        bad++;
        $display("FAIL b2b_order c=%0d got %b/%b want %b/%b", c,
                 s_awready, AWVALID, 4'(1 << (c % 4)), c > 0);
      end
      total++;
      if (obs() !== expv()) begin
        bad++;
        $display("FAIL b2b_data c=%0d got %h want %h", c, obs(), expv());
      end
      commit();
    end
  endtask

  task automatic test_stall();
    do_reset();
    rand_fields();
    s_awvalid = 4'b0001;
    s_awaddr[0 +: AW] = 32'h40;
    AWREADY = 0;
    @(negedge ACLK);
    predict();
    total++;
    if (s_awready !== 4'b0001) begin
      bad++;
      $display("FAIL stall_load got %b want 0001", s_awready);
    end
    commit();
    for (int c = 1; c <= 6; c++) begin
      AWREADY = (c == 6);
      @(negedge ACLK);
      predict();
      total++;
      if ({AWVALID, AWADDR, s_awready} !==
          {1'b1, 32'h40, (c == 6) ? 4'b0001 : 4'b0000}) begin
        bad++;
        $display("FAIL stall_hold c=%0d got %b/%h/%b", c,
                 AWVALID, AWADDR, s_awready);
      end
      total++;
      if (obs() !== expv()) begin
        bad++;
        $display("FAIL stall_all c=%0d got %h want %h", c, obs(), expv());
      end
      commit();
    end
  endtask

  task automatic test_qos();
    logic [N-1:0] want;
`ifdef RH_AXI4_AW_ARB_QOS_EN
    want = 4'b1000;
`else
    want = 4'b0010;
`endif
    do_reset();
    rand_fields();
    s_awqos = '0;
    s_awqos[1*4 +: 4] = 4'd3;
    s_awqos[3*4 +: 4] = 4'd9;
    s_awvalid = 4'b1010;
    AWREADY = 1;
    @(negedge ACLK);
    predict();
    total++;
    if (s_awready !== want) begin
      bad++;
      $display("FAIL qos_pick got %b want %b", s_awready, want);
    end
    commit();
  endtask

  task automatic test_fairness();
    logic [N-1:0] pat [5];
    logic [N-1:0] rdy [5];
    pat = '{4'b0001, 4'b1010, 4'b1000, 4'b1000, 4'b1010};
    rdy = '{4'b0001, 4'b0000, 4'b0000, 4'b1000, 4'b0010};
    do_reset();
    rand_fields();
    s_awqos = '0;
    for (int c = 0; c < 5; c++) begin
      s_awvalid = pat[c];
      AWREADY = (c >= 3);
      @(negedge ACLK);
      predict();
      total++;
      if (s_awready !== rdy[c]) begin
        bad++;
        $display("FAIL fair c=%0d got %b want %b", c, s_awready, rdy[c]);
      end
      total++;
      if (obs() !== expv()) begin
        bad++;
        $display("FAIL fair_all c=%0d got %h want %h", c, obs(), expv());
      end
      commit();
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      rand_fields();
      s_awvalid = 4'($urandom);
      AWREADY = ($urandom_range(0, 3) != 0);
      @(negedge ACLK);
      predict();
      total++;
      if (obs() !== expv()) begin
        bad++;
        $display("FAIL random c=%0d got %h want %h", c, obs(), expv());
      end
      commit();
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    ARESET = 1;
    AWREADY = 0;
    s_awvalid = '0;
    s_awid = '0; s_awaddr = '0; s_awlen = '0; s_awsize = '0;
    s_awburst = '0; s_awlock = '0; s_awcache = '0; s_awprot = '0;
    s_awqos = '0; s_awregion = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_qos();
    test_fairness();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
